// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_pkg
// Purpose  : Shared register map, status layout and FSM state encoding for
//            the UART register-access controller.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package uart_pkg;

  // Register offsets carried in command byte bits [3:1]
  localparam logic [2:0] UART_CR_OFFSET    = 3'd0;
  localparam logic [2:0] UART_SR_OFFSET    = 3'd1;
  localparam logic [2:0] UART_DINL_OFFSET  = 3'd2;
  localparam logic [2:0] UART_DINH_OFFSET  = 3'd3;
  localparam logic [2:0] UART_DOUTL_OFFSET = 3'd4;
  localparam logic [2:0] UART_DOUTM_OFFSET = 3'd5;
  localparam logic [2:0] UART_DOUTH_OFFSET = 3'd6;

  // Command byte bit selecting write (1) or read (0)
  localparam int UART_CMD_WRITE_BIT = 0;

  // Status register as seen by the host
  typedef struct packed {
    logic [2:0] rsvd;
    logic       proto_err;
    logic       din_ovf;
    logic       dout_ovf;
    logic       din_pend;
    logic       dout_valid;
  } uart_sr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDATA  = 2'd1,
    RDSEND = 2'd2
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/rpeak_out_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rpeak_out_buf
// Purpose  : Single-entry R-peak location buffer with overflow flag and a
//            shadow copy taken on the low-byte read so the three readout
//            bytes always belong to the same capture.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module rpeak_out_buf #(
  parameter int CTR_WIDTH = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CTR_WIDTH-1:0] rpeak_loc_i,
  input  logic                 rpeak_valid_i,
  input  logic                 snap_i,      // DOUTL read accepted
  input  logic                 clr_i,       // DOUTH read accepted
  input  logic                 ovf_clr_i,   // host clears sticky flags
  output logic [7:0]           byte0_o,
  output logic [7:0]           byte1_o,
  output logic [7:0]           byte2_o,
  output logic                 dout_valid_o,
  output logic                 dout_ovf_o
);

  logic [23:0] buf_q, buf_d;
  // Byte 0 is returned live on the DOUTL read, so only bytes 1..2 need a shadow
  logic [15:0] shadow_q, shadow_d;
  logic        dout_valid_q, dout_valid_d;
  logic        dout_ovf_q, dout_ovf_d;
  logic        accept, ovf_set;

  // A clear in the same cycle frees the slot, so the new capture is taken
  assign accept  = rpeak_valid_i && (!dout_valid_q || clr_i);
  assign ovf_set = rpeak_valid_i && dout_valid_q && !clr_i;

  // Next-state for buffer, shadow and flags; capture overrides the read clear
  always_comb begin
    buf_d        = buf_q;
    shadow_d     = shadow_q;
    dout_valid_d = dout_valid_q;
    dout_ovf_d   = ovf_set | (dout_ovf_q & ~ovf_clr_i);
    if (snap_i) shadow_d = buf_q[23:8];
    if (clr_i)  dout_valid_d = 1'b0;
    if (accept) begin
      buf_d        = 24'(rpeak_loc_i);
      dout_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q        <= '0;
      shadow_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_ovf_q   <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      shadow_q     <= shadow_d;
      dout_valid_q <= dout_valid_d;
      dout_ovf_q   <= dout_ovf_d;
    end
  end

  assign byte0_o      = buf_q[7:0];
  assign byte1_o      = shadow_q[7:0];
  assign byte2_o      = shadow_q[15:8];
  assign dout_valid_o = dout_valid_q;
  assign dout_ovf_o   = dout_ovf_q;

endmodule
`default_nettype wire

// File: rtl/uart_reg_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_reg_ctrl
// Purpose  : Byte-level register-access controller between the UART byte
//            streams and the R-peak detection core. Decodes host commands,
//            assembles ECG samples and returns buffered R-peak locations.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_reg_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 11,
  parameter int CTR_WIDTH      = 22,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  input  logic [CTR_WIDTH-1:0]  rpeak_loc,
  input  logic                  rpeak_valid,
  output logic                  alg_en
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  uart_state_t           state_q, state_d;
  logic [2:0]            addr_q, addr_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [7:0]            cr_q, cr_d;
  logic [7:0]            dinl_q, dinl_d;
  logic [7:0]            dinh_q, dinh_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] sample_data_q, sample_data_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  proto_err_q, proto_err_d;
  logic                  din_ovf_q, din_ovf_d;

  logic                  proto_set, din_ovf_set, flag_clr;
  logic                  rd_snap, rd_clr;
  logic [2:0]            cmd_addr;
  logic [7:0]            rd_val;
  uart_sr_t              sr;
  logic [7:0]            dout_b0, dout_b1, dout_b2;
  logic                  dout_valid, dout_ovf;

  assign cmd_addr = rx_data[3:1];

  rpeak_out_buf #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_rpeak_out_buf (
    .clk           (clk),
    .rst           (rst),
    .rpeak_loc_i   (rpeak_loc),
    .rpeak_valid_i (rpeak_valid),
    .snap_i        (rd_snap),
    .clr_i         (rd_clr),
    .ovf_clr_i     (flag_clr),
    .byte0_o       (dout_b0),
    .byte1_o       (dout_b1),
    .byte2_o       (dout_b2),
    .dout_valid_o  (dout_valid),
    .dout_ovf_o    (dout_ovf)
  );

  // Read-data mux addressed directly by the incoming command byte
  always_comb begin
    sr            = '0;
    sr.proto_err  = proto_err_q;
    sr.din_ovf    = din_ovf_q;
    sr.dout_ovf   = dout_ovf;
    sr.din_pend   = sample_valid_q;
    sr.dout_valid = dout_valid;
    case (cmd_addr)
      UART_CR_OFFSET:    rd_val = cr_q;
      UART_SR_OFFSET:    rd_val = sr;
      UART_DINL_OFFSET:  rd_val = dinl_q;
      UART_DINH_OFFSET:  rd_val = dinh_q;
      UART_DOUTL_OFFSET: rd_val = dout_b0;
      UART_DOUTM_OFFSET: rd_val = dout_b1;
      UART_DOUTH_OFFSET: rd_val = dout_b2;
      default:           rd_val = 8'h00;
    endcase
  end

  // Command FSM next-state, register writes and sticky-flag updates
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    to_cnt_d       = to_cnt_q;
    cr_d           = cr_q;
    dinl_d         = dinl_q;
    dinh_d         = dinh_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = sample_valid_q;
    proto_set      = 1'b0;
    din_ovf_set    = 1'b0;
    flag_clr       = 1'b0;
    rd_snap        = 1'b0;
    rd_clr         = 1'b0;

    if (sample_valid_q && sample_ready) sample_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data[7:4] != 4'd0) begin
            proto_set = 1'b1;
          end else if (rx_data[UART_CMD_WRITE_BIT]) begin
            addr_d   = cmd_addr;
            to_cnt_d = '0;
            state_d  = WDATA;
          end else begin
            tx_data_d  = rd_val;
            tx_valid_d = 1'b1;
            rd_snap    = (cmd_addr == UART_DOUTL_OFFSET);
            rd_clr     = (cmd_addr == UART_DOUTH_OFFSET);
            state_d    = RDSEND;
          end
        end
      end
      WDATA: begin
        if (rx_valid) begin
          state_d = IDLE;
          case (addr_q)
            UART_CR_OFFSET: begin
              // Bit 1 is a write-1-clear strobe and is never stored
              cr_d     = {rx_data[7:2], 1'b0, rx_data[0]};
              flag_clr = rx_data[1];
            end
            UART_DINL_OFFSET: dinl_d = rx_data;
            UART_DINH_OFFSET: begin
              dinh_d = rx_data;
              // A sample still waiting after this cycle cannot be replaced
              if (sample_valid_q && !sample_ready) begin
                din_ovf_set = 1'b1;
              end else begin
                sample_data_d  = {rx_data[DATA_WIDTH-9:0], dinl_q};
                sample_valid_d = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (to_cnt_q == TO_LAST) begin
          proto_set = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      RDSEND: begin
        if (rx_valid) proto_set = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set events win over a simultaneous host clear
    proto_err_d = proto_set   | (proto_err_q & ~flag_clr);
    din_ovf_d   = din_ovf_set | (din_ovf_q   & ~flag_clr);
  end

  // State and register storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      to_cnt_q       <= '0;
      cr_q           <= '0;
      dinl_q         <= '0;
      dinh_q         <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      proto_err_q    <= 1'b0;
      din_ovf_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      to_cnt_q       <= to_cnt_d;
      cr_q           <= cr_d;
      dinl_q         <= dinl_d;
      dinh_q         <= dinh_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      proto_err_q    <= proto_err_d;
      din_ovf_q      <= din_ovf_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign alg_en       = cr_q[0];

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_uart_reg_ctrl
// Purpose  : Self-checking bench for uart_reg_ctrl: directed scenarios plus a
//            randomized command stream checked against a register-level model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_uart_reg_ctrl;

  localparam int DW = 11;
  localparam int CW = 22;
  localparam int TO = 20000;

  localparam logic [2:0] A_CR = 3'd0, A_SR = 3'd1, A_DINL = 3'd2, A_DINH = 3'd3;
  localparam logic [2:0] A_DOUTL = 3'd4, A_DOUTM = 3'd5, A_DOUTH = 3'd6;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic [CW-1:0] rpeak_loc;
  logic          rpeak_valid;
  logic          alg_en;

  int errors = 0;
  int checks = 0;

  // Register-level reference model
  logic [7:0]    m_cr, m_dinl, m_dinh;
  logic          m_proto, m_dinovf, m_doutovf, m_pend, m_dv;
  logic [23:0]   m_buf, m_shadow;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic          mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_reg_ctrl #(
    .DATA_WIDTH     (DW),
    .CTR_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .rpeak_loc    (rpeak_loc),
    .rpeak_valid  (rpeak_valid),
    .alg_en       (alg_en)
  );

  // Sample handshake monitor for the randomized phase
  always @(negedge clk) begin
    if (mon_en && sample_valid === 1'b1 && sample_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rand_sample: got unexpected sample %h, expected none", sample_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (sample_data !== mon_exp) begin
          errors++;
          $display("FAIL rand_sample: got %h expected %h", sample_data, mon_exp);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    send_byte({4'b0, a, 1'b1});
    send_byte(d);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    int n;
    send_byte({4'b0, a, 1'b0});
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL read_handshake addr=%0d: tx_valid=%b expected 1", a, tx_valid); end
    d = tx_data;
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask

  task automatic pulse_rpeak(input logic [CW-1:0] loc);
    rpeak_loc = loc; rpeak_valid = 1'b1;
    @(posedge clk); #1;
    rpeak_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got valid=%b data=%h expected 0/00", tx_valid, tx_data); end
    checks++; if (sample_valid !== 1'b0 || sample_data !== '0) begin errors++; $display("FAIL reset_sample: got valid=%b data=%h expected 0/000", sample_valid, sample_data); end
    checks++; if (alg_en !== 1'b0) begin errors++; $display("FAIL reset_alg_en: got %b expected 0", alg_en); end
    for (int a = 0; a < 8; a++) begin
      read_reg(3'(a), v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg addr=%0d: got %h expected 00", a, v); end
    end
  endtask

  task automatic test_sample();
    logic [7:0] v;
    sample_ready = 1'b1;
    write_reg(A_DINL, 8'hF3);
    write_reg(A_DINH, 8'h03);
    checks++; if (sample_valid !== 1'b1 || sample_data !== 11'h3F3) begin errors++; $display("FAIL sample_out: got valid=%b data=%h expected 1/3f3", sample_valid, sample_data); end
    @(posedge clk); #1;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL sample_one_cycle: got valid=%b expected 0", sample_valid); end
    read_reg(A_SR, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL sample_sr: got %h expected 00", v); end
  endtask

  task automatic test_din_ovf();
    logic [7:0] v;
    sample_ready = 1'b0;
    write_reg(A_DINL, 8'h11);
    write_reg(A_DINH, 8'h05);
    write_reg(A_DINH, 8'h06);
    checks++; if (sample_valid !== 1'b1 || sample_data !== 11'h511) begin errors++; $display("FAIL ovf_held: got valid=%b data=%h expected 1/511", sample_valid, sample_data); end
    read_reg(A_SR, v);
    checks++; if (v !== 8'h0A) begin errors++; $display("FAIL ovf_sr: got %h expected 0a", v); end
    write_reg(A_CR, 8'h02);
    read_reg(A_SR, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL ovf_clear_sr: got %h expected 02", v); end
    read_reg(A_CR, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL ovf_cr_bit1: got %h expected 00", v); end
    sample_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: got valid=%b expected 0", sample_valid); end
    read_reg(A_DINH, v);
    checks++; if (v !== 8'h06) begin errors++; $display("FAIL ovf_dinh: got %h expected 06", v); end
  endtask

  task automatic test_cr();
    logic [7:0] v;
    write_reg(A_CR, 8'hFD);
    read_reg(A_CR, v);
    checks++; if (v !== 8'hFD || alg_en !== 1'b1) begin errors++; $display("FAIL cr_fd: got %h alg_en=%b expected fd/1", v, alg_en); end
    write_reg(A_CR, 8'hFE);
    read_reg(A_CR, v);
    checks++; if (v !== 8'hFC || alg_en !== 1'b0) begin errors++; $display("FAIL cr_fe: got %h alg_en=%b expected fc/0", v, alg_en); end
    write_reg(A_CR, 8'h00);
  endtask

  task automatic test_rpeak();
    logic [7:0] v;
    pulse_rpeak(22'h2A5C3E);
    read_reg(A_SR, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL rpeak_sr_before: got %h expected 01", v); end
    read_reg(A_DOUTL, v);
    checks++; if (v !== 8'h3E) begin errors++; $display("FAIL rpeak_l: got %h expected 3e", v); end
    read_reg(A_DOUTM, v);
    checks++; if (v !== 8'h5C) begin errors++; $display("FAIL rpeak_m: got %h expected 5c", v); end
    read_reg(A_DOUTH, v);
    checks++; if (v !== 8'h2A) begin errors++; $display("FAIL rpeak_h: got %h expected 2a", v); end
    read_reg(A_SR, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rpeak_sr_after: got %h expected 00", v); end
    // Second capture arriving mid-readout
    pulse_rpeak(22'h123456);
    read_reg(A_DOUTL, v);
    checks++; if (v !== 8'h56) begin errors++; $display("FAIL rpeak2_l: got %h expected 56", v); end
    pulse_rpeak(22'h0ABCDE);
    read_reg(A_DOUTM, v);
    checks++; if (v !== 8'h34) begin errors++; $display("FAIL rpeak2_m: got %h expected 34", v); end
    read_reg(A_SR, v);
    checks++; if (v !== 8'h05) begin errors++; $display("FAIL rpeak2_ovf_sr: got %h expected 05", v); end
    write_reg(A_CR, 8'h02);
    // DOUTH read and new capture in the same cycle
    rx_data = {4'b0, A_DOUTH, 1'b0}; rx_valid = 1'b1;
    rpeak_loc = 22'h3BEEF0; rpeak_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rpeak_valid = 1'b0; tx_ready = 1'b1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin errors++; $display("FAIL rpeak2_h: got valid=%b data=%h expected 1/12", tx_valid, tx_data); end
    @(posedge clk); #1;
    tx_ready = 1'b0;
    read_reg(A_SR, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL rpeak_capture_wins_sr: got %h expected 01", v); end
    read_reg(A_DOUTL, v);
    checks++; if (v !== 8'hF0) begin errors++; $display("FAIL rpeak3_l: got %h expected f0", v); end
    read_reg(A_DOUTM, v);
    read_reg(A_DOUTH, v);
    checks++; if (v !== 8'h3B) begin errors++; $display("FAIL rpeak3_h: got %h expected 3b", v); end
    // Overflow set coincident with the flag clear: set wins
    pulse_rpeak(22'h000001);
    send_byte({4'b0, A_CR, 1'b1});
    rx_data = 8'h02; rx_valid = 1'b1; rpeak_loc = 22'h000002; rpeak_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rpeak_valid = 1'b0;
    read_reg(A_SR, v);
    checks++; if (v !== 8'h05) begin errors++; $display("FAIL flag_set_wins: got %h expected 05", v); end
    write_reg(A_CR, 8'h02);
    read_reg(A_DOUTL, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL flag_set_wins_l: got %h expected 01", v); end
    read_reg(A_DOUTH, v);
    read_reg(A_SR, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rpeak_final_sr: got %h expected 00", v); end
  endtask

  task automatic test_proto();
    logic [7:0] v;
    int stall_bad;
    send_byte(8'h90);
    read_reg(A_SR, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL proto_90: got %h expected 10", v); end
    write_reg(A_CR, 8'h02);
    send_byte(8'h23);
    read_reg(A_SR, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL proto_23: got %h expected 10", v); end
    write_reg(A_CR, 8'h02);
    // Stalled read of DINL with a stray byte during RDSEND
    send_byte({4'b0, A_DINL, 1'b0});
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      rx_valid = (i == 10); rx_data = 8'h03;
      @(posedge clk); #1;
      if (tx_valid !== 1'b1 || tx_data !== 8'h11) stall_bad++;
    end
    rx_valid = 1'b0;
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL proto_stall: got %0d unstable cycles (data=%h) expected 0", stall_bad, tx_data); end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL proto_release: got valid=%b expected 0", tx_valid); end
    read_reg(A_SR, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL proto_rdsend: got %h expected 10", v); end
    read_reg(A_CR, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL proto_cr_untouched: got %h expected 00", v); end
    write_reg(A_CR, 8'h02);
  endtask

  task automatic test_timeout();
    logic [7:0] v;
    int seen;
    sample_ready = 1'b1;
    // Data byte exactly TO cycles after the command is still accepted
    send_byte({4'b0, A_DINH, 1'b1});
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'h02);
    checks++; if (sample_valid !== 1'b1 || sample_data !== 11'h211) begin errors++; $display("FAIL timeout_edge_ok: got valid=%b data=%h expected 1/211", sample_valid, sample_data); end
    @(posedge clk); #1;
    read_reg(A_SR, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL timeout_edge_sr: got %h expected 00", v); end
    // No data byte at all: abort after TO cycles
    send_byte({4'b0, A_DINH, 1'b1});
    seen = 0;
    repeat (TO) begin @(posedge clk); #1; if (sample_valid !== 1'b0) seen++; end
    read_reg(A_SR, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL timeout_sr: got %h expected 10", v); end
    checks++; if (seen != 0) begin errors++; $display("FAIL timeout_no_sample: got %0d valid cycles expected 0", seen); end
    read_reg(A_DINH, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL timeout_dinh: got %h expected 02", v); end
    write_reg(A_CR, 8'h02);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    sample_ready = 1'b0;
    write_reg(A_CR, 8'h01);
    write_reg(A_DINL, 8'h22);
    write_reg(A_DINH, 8'h01);
    pulse_rpeak(22'h001234);
    send_byte({4'b0, A_SR, 1'b0});
    checks++; if (tx_valid !== 1'b1 || sample_valid !== 1'b1 || alg_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got tx=%b smp=%b en=%b expected 1/1/1", tx_valid, sample_valid, alg_en); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx_valid !== 1'b0 || sample_valid !== 1'b0 || alg_en !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got tx=%b smp=%b en=%b expected 0/0/0", tx_valid, sample_valid, alg_en); end
    rst = 1'b0;
    read_reg(A_SR, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rstmid_sr: got %h expected 00", v); end
    sample_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rstmid_sample_lost: got %b expected 0", sample_valid); end
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a);
    case (a)
      A_CR:    return m_cr;
      A_SR:    return {3'b0, m_proto, m_dinovf, m_doutovf, m_pend, m_dv};
      A_DINL:  return m_dinl;
      A_DINH:  return m_dinh;
      A_DOUTL: return m_buf[7:0];
      A_DOUTM: return m_shadow[15:8];
      A_DOUTH: return m_shadow[23:16];
      default: return 8'h00;
    endcase
  endfunction

  task automatic test_random();
    logic [7:0]    d, got, expv, b;
    logic [2:0]    a;
    logic [CW-1:0] loc;
    int            op;
    do_reset();
    m_cr = 0; m_dinl = 0; m_dinh = 0; m_proto = 0; m_dinovf = 0; m_doutovf = 0;
    m_pend = 0; m_dv = 0; m_buf = 0; m_shadow = 0;
    exp_q.delete();
    mon_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      sample_ready = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 9);
      if (op < 4) begin
        a = 3'($urandom_range(0, 7)); d = 8'($urandom);
        if (m_pend && sample_ready) m_pend = 0;
        write_reg(a, d);
        case (a)
          A_CR: begin
            m_cr = {d[7:2], 1'b0, d[0]};
            if (d[1]) begin m_proto = 0; m_dinovf = 0; m_doutovf = 0; end
          end
          A_DINL: m_dinl = d;
          A_DINH: begin
            m_dinh = d;
            if (m_pend) m_dinovf = 1;
            else begin m_pend = 1; exp_q.push_back(DW'({d, m_dinl})); end
          end
          default: ;
        endcase
      end else if (op < 8) begin
        a = 3'($urandom_range(0, 7));
        expv = model_read(a);
        if (a == A_DOUTL) m_shadow = m_buf;
        if (a == A_DOUTH) m_dv = 0;
        if (m_pend && sample_ready) m_pend = 0;
        read_reg(a, got);
        checks++; if (got !== expv) begin errors++; $display("FAIL rand_read it=%0d addr=%0d: got %h expected %h", k, a, got, expv); end
      end else if (op == 8) begin
        loc = CW'($urandom);
        if (m_pend && sample_ready) m_pend = 0;
        pulse_rpeak(loc);
        if (!m_dv) begin m_buf = 24'(loc); m_dv = 1; end
        else m_doutovf = 1;
      end else begin
        b = 8'($urandom);
        if (b[7:4] == 4'h0) b[7:4] = 4'h8;
        if (m_pend && sample_ready) m_pend = 0;
        send_byte(b);
        m_proto = 1;
      end
      checks++; if (alg_en !== m_cr[0]) begin errors++; $display("FAIL rand_alg_en it=%0d: got %b expected %b", k, alg_en, m_cr[0]); end
    end
    sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing_samples: got %0d outstanding expected 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    sample_ready = 1'b0; rpeak_loc = '0; rpeak_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_sample();
    test_din_ovf();
    test_cr();
    test_rpeak();
    test_proto();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
